// File: rtl/out_port_ctrl.sv
// Per-output port controller: requests a grant from this output's arbiter, latches it,
// and forwards one packet from the granted input through a registered valid/ready stage.
module out_port_ctrl #(
   parameter logic [1:0] OUT_ID      = 2'd0,
   parameter int         DATA_W      = 8,
   parameter int         MAX_LEN     = 64,
   parameter int         ARB_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            requests,
   input  logic [7:0]            address,
   input  logic [2:0]            arbiter_answer,
   input  logic                  ArbR,
   output logic [2:0]            STATE,
   input  logic [4*DATA_W-1:0]   in_data,
   input  logic [3:0]            in_valid,
   input  logic [3:0]            in_last,
   output logic [3:0]            in_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [15:0]           pkt_count,
   output logic                  trunc_err
);

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      ARB  = 3'b001,
      XFER = 3'b010,
      DONE = 3'b011
   } state_t;

   localparam logic [7:0] MAX_LEN_C  = 8'(MAX_LEN);
   localparam logic [3:0] ARB_LAST_C = 4'(ARB_TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic [7:0]          beat_cnt_q, beat_cnt_d;
   logic [3:0]          arb_timer_q, arb_timer_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [15:0]         pkt_count_q, pkt_count_d;
   logic                trunc_err_q, trunc_err_d;

   logic                req_pending;
   logic                accept;
   logic                beat_take;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic [7:0]          beat_next;
   logic                trunc_hit;

   always_comb begin
      req_pending = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (requests[i] && (address[2*i +: 2] == OUT_ID)) begin
            req_pending = 1'b1;
         end
      end
   end

   // The output register can take a new beat when empty or draining this cycle.
   assign accept    = out_ready | ~out_valid_q;
   assign sel_data  = in_data[DATA_W*grant_q +: DATA_W];
   assign sel_last  = in_last[grant_q];
   assign beat_take = (state_q == XFER) && in_valid[grant_q] && accept;
   assign beat_next = beat_cnt_q + 8'd1;
   assign trunc_hit = !sel_last && (beat_next == MAX_LEN_C);
   assign in_ready  = ((state_q == XFER) && accept) ? (4'b0001 << grant_q) : 4'b0000;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      beat_cnt_d  = beat_cnt_q;
      arb_timer_d = arb_timer_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      pkt_count_d = pkt_count_q;
      trunc_err_d = trunc_err_q;

      if (beat_take) begin
         out_data_d  = sel_data;
         out_valid_d = 1'b1;
         out_last_d  = sel_last | trunc_hit;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            arb_timer_d = 4'd0;
            if (req_pending) begin
               state_d = ARB;
            end
         end
         ARB: begin
            // A grant beats a timeout that expires in the same cycle.
            if (ArbR && !arbiter_answer[2]) begin
               grant_d    = arbiter_answer[1:0];
               beat_cnt_d = 8'd0;
               state_d    = XFER;
            end else if (arb_timer_q == ARB_LAST_C) begin
               state_d = IDLE;
            end else begin
               arb_timer_d = arb_timer_q + 4'd1;
            end
         end
         XFER: begin
            if (beat_take) begin
               beat_cnt_d = beat_next;
               if (sel_last || trunc_hit) begin
                  state_d = DONE;
               end
               if (trunc_hit) begin
                  trunc_err_d = 1'b1;
               end
            end
         end
         DONE: begin
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= 2'd0;
         beat_cnt_q  <= 8'd0;
         arb_timer_q <= 4'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pkt_count_q <= 16'd0;
         trunc_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         beat_cnt_q  <= beat_cnt_d;
         arb_timer_q <= arb_timer_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         pkt_count_q <= pkt_count_d;
         trunc_err_q <= trunc_err_d;
      end
   end

   assign STATE     = state_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign pkt_count = pkt_count_q;
   assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Bench for out_port_ctrl: per-input beat sources, a small registered arbiter model,
// and a scoreboard of expected output beats built when packets are queued.
module tb_out_port_ctrl;

   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 4;

   localparam logic [2:0] S_IDLE = 3'b000;
   localparam logic [2:0] S_ARB  = 3'b001;
   localparam logic [2:0] S_XFER = 3'b010;
   localparam logic [2:0] S_DONE = 3'b011;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [3:0]          requests = '0;
   logic [7:0]          address = '0;
   logic [2:0]          arbiter_answer = 3'b100;
   logic                ArbR = 1'b0;
   logic [2:0]          STATE;
   logic [4*DATA_W-1:0] in_data = '0;
   logic [3:0]          in_valid = '0;
   logic [3:0]          in_last = '0;
   logic [3:0]          in_ready;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_last;
   logic                out_ready = 1'b1;
   logic [15:0]         pkt_count;
   logic                trunc_err;

   int                  checks = 0;
   int                  errors = 0;
   int                  exp_pkts = 0;
   logic                arb_en = 1'b1;
   int                  arb_cyc = 0;

   logic [8:0]          src_q [4][$];
   logic [8:0]          exp_q [$];

   always #5 clk = ~clk;

   out_port_ctrl #(
      .OUT_ID      (2'd0),
      .DATA_W      (DATA_W),
      .MAX_LEN     (MAX_LEN),
      .ARB_TIMEOUT (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .requests       (requests),
      .address        (address),
      .arbiter_answer (arbiter_answer),
      .ArbR           (ArbR),
      .STATE          (STATE),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_last       (out_last),
      .out_ready      (out_ready),
      .pkt_count      (pkt_count),
      .trunc_err      (trunc_err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Queue a packet at an input; the expected output follows the MAX_LEN cut rule,
   // with any leftover beats forming the next packet from the same input.
   task automatic push_pkt(input int idx, input logic [7:0] base, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) begin
         logic       lst;
         logic [7:0] d;
         d = base + 8'(k);
         src_q[idx].push_back({(k == n - 1), d});
         c++;
         lst = (k == n - 1) || (c == MAX_LEN);
         exp_q.push_back({lst, d});
         if (lst) begin
            c = 0;
            exp_pkts++;
         end
      end
   endtask

   // One clock: observe at the falling edge, then update sources and arbiter 1ns after the rising edge.
   task automatic tick();
      logic [3:0] take;
      logic [2:0] pick;
      logic [8:0] e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", {23'd0, out_last, out_data}, 32'h1ff);
         end else begin
            e = exp_q.pop_front();
            check("beat", {23'd0, out_last, out_data}, {23'd0, e});
         end
      end
      if (out_valid && !out_ready) begin
         check("in_ready_when_full", {28'd0, in_ready}, 32'd0);
      end
      take = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (take[i] && src_q[i].size() != 0) begin
            src_q[i].delete(0);
         end
         requests[i] = (src_q[i].size() != 0);
         in_valid[i] = (src_q[i].size() != 0);
         in_data[DATA_W*i +: DATA_W] = (src_q[i].size() != 0) ? src_q[i][0][7:0] : 8'h00;
         in_last[i] = (src_q[i].size() != 0) ? src_q[i][0][8] : 1'b0;
      end
      pick = 3'b100;
      for (int i = 3; i >= 0; i--) begin
         if (requests[i] && address[2*i +: 2] == 2'd0) pick = 3'(i);
      end
      if (STATE == S_ARB) arb_cyc++;
      else arb_cyc = 0;
      if (STATE == S_ARB && arb_cyc >= 2) begin
         ArbR = 1'b1;
         arbiter_answer = arb_en ? pick : 3'b100;
      end else begin
         ArbR = 1'b0;
         arbiter_answer = 3'b100;
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
      int n = 0;
      while (STATE != target && n < budget) begin
         tick();
         n++;
      end
      check(tag, {29'd0, STATE}, {29'd0, target});
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid || STATE != S_IDLE) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_left"}, exp_q.size(), 32'd0);
      check({tag, "_pkts"}, {16'd0, pkt_count}, exp_pkts);
   endtask

   initial begin
      int n;
      tick();
      tick();
      check("rst_state", {29'd0, STATE}, 32'd0);
      check("rst_in_ready", {28'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
      check("rst_trunc_err", {31'd0, trunc_err}, 32'd0);
      reset = 1'b0;
      tick();

      // Request to another output is ignored
      address = 8'b0000_0100;
      src_q[1].push_back(9'h1ee);
      for (int i = 0; i < 5; i++) tick();
      check("foreign_req_idle", {29'd0, STATE}, {29'd0, S_IDLE});
      src_q[1].delete();
      address = 8'h00;
      tick();

      // Basic 3-beat packet from input 2
      push_pkt(2, 8'hA1, 3);
      wait_state("t1_xfer", S_XFER, 20);
      wait_state("t1_done", S_DONE, 20);
      tick();
      check("t1_done_to_idle", {29'd0, STATE}, {29'd0, S_IDLE});
      drain("t1", 40);

      // Same packet with a 5-cycle downstream stall
      push_pkt(2, 8'hA1, 3);
      wait_state("t2_xfer", S_XFER, 20);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b1;
      drain("t2", 40);

      // Arbiter answers "no grant" until the ARB timer expires
      arb_en = 1'b0;
      push_pkt(1, 8'hC1, 1);
      wait_state("t3_arb", S_ARB, 20);
      n = 0;
      while (STATE == S_ARB && n < 20) begin
         tick();
         n++;
      end
      check("t3_arb_cycles", n, 32'd4);
      check("t3_back_idle", {29'd0, STATE}, {29'd0, S_IDLE});
      tick();
      check("t3_rearb", {29'd0, STATE}, {29'd0, S_ARB});
      arb_en = 1'b1;
      drain("t3", 40);

      // 6-beat packet cut at MAX_LEN; the rest follows as a separate packet
      check("t4_trunc_before", {31'd0, trunc_err}, 32'd0);
      push_pkt(1, 8'hD1, 6);
      wait_state("t4_done", S_DONE, 40);
      check("t4_trunc_set", {31'd0, trunc_err}, 32'd1);
      check("t4_in_ready_done", {28'd0, in_ready}, 32'd0);
      tick();
      check("t4_in_ready_idle", {28'd0, in_ready}, 32'd0);
      drain("t4", 60);
      check("t4_trunc_sticky", {31'd0, trunc_err}, 32'd1);

      // Inputs 0 and 3 contend; lower index wins first
      push_pkt(0, 8'hE1, 2);
      push_pkt(3, 8'hF1, 2);
      wait_state("t6_done", S_DONE, 40);
      tick();
      check("t6_idle_gap", {29'd0, STATE}, {29'd0, S_IDLE});
      drain("t6", 60);

      // Reset in the middle of a transfer
      push_pkt(2, 8'h51, 3);
      wait_state("t5_xfer", S_XFER, 20);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) src_q[i].delete();
      tick();
      check("t5_state", {29'd0, STATE}, 32'd0);
      check("t5_out_valid", {31'd0, out_valid}, 32'd0);
      check("t5_out_last", {31'd0, out_last}, 32'd0);
      check("t5_in_ready", {28'd0, in_ready}, 32'd0);
      check("t5_pkt_count", {16'd0, pkt_count}, 32'd0);
      check("t5_trunc_err", {31'd0, trunc_err}, 32'd0);
      exp_q.delete();
      exp_pkts = 0;
      reset = 1'b0;
      tick();
      push_pkt(3, 8'h61, 2);
      drain("t5_after", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
